// File: rtl/arp_rx.sv
// Receive-side ARP parser: validates ARP frames byte by byte, raises a reply
// request for ARP requests addressed to us and pulses arp_found for ARP replies.
module arp_rx #(
    parameter int MIN_ARP_BYTES = 42,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] local_mac_addr,
    input  logic [31:0] local_ip_addr,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_valid,
    input  logic        rx_frame_end,
    input  logic        rx_frame_err,
    input  logic        arp_reply_ack,
    output logic        arp_reply_req,
    output logic [47:0] arp_rec_source_mac_addr,
    output logic [31:0] arp_rec_source_ip_addr,
    output logic        arp_found
);

    typedef enum logic [1:0] {IDLE, RECV, DROP, CHECK} state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             bcast_match_reg;
    logic             local_match_reg;
    logic             op_reply_reg;
    logic [47:0]      sha_reg;
    logic [31:0]      spa_reg;

    int   off;
    logic bcast_next;
    logic local_next;
    logic mismatch;
    logic exp_en;
    logic [7:0] exp_byte;

    // The first byte of a frame arrives in IDLE and is checked as offset 0.
    always_comb begin
        off        = (state_reg == IDLE) ? 0 : int'(cnt_reg);
        bcast_next = (off == 0) ? 1'b1 : bcast_match_reg;
        local_next = (off == 0) ? 1'b1 : local_match_reg;
        mismatch   = 1'b0;
        exp_en     = 1'b0;
        exp_byte   = 8'h00;
        case (off)
            0, 1, 2, 3, 4, 5: begin
                // Broadcast and unicast tracked separately so bytes cannot mix.
                bcast_next = bcast_next & (rx_data == 8'hff);
                local_next = local_next & (rx_data == local_mac_addr[8*(5-off) +: 8]);
                mismatch   = !(bcast_next || local_next);
            end
            12: begin exp_en = 1'b1; exp_byte = 8'h08; end
            13: begin exp_en = 1'b1; exp_byte = 8'h06; end
            14: begin exp_en = 1'b1; exp_byte = 8'h00; end
            15: begin exp_en = 1'b1; exp_byte = 8'h01; end
            16: begin exp_en = 1'b1; exp_byte = 8'h08; end
            17: begin exp_en = 1'b1; exp_byte = 8'h00; end
            18: begin exp_en = 1'b1; exp_byte = 8'h06; end
            19: begin exp_en = 1'b1; exp_byte = 8'h04; end
            20: begin exp_en = 1'b1; exp_byte = 8'h00; end
            21: mismatch = !((rx_data == 8'h01) || (rx_data == 8'h02));
            38, 39, 40, 41: begin
                exp_en   = 1'b1;
                exp_byte = local_ip_addr[8*(41-off) +: 8];
            end
            default: ;
        endcase
        if (exp_en && (rx_data != exp_byte))
            mismatch = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg               <= IDLE;
            cnt_reg                 <= '0;
            bcast_match_reg         <= 1'b0;
            local_match_reg         <= 1'b0;
            op_reply_reg            <= 1'b0;
            sha_reg                 <= '0;
            spa_reg                 <= '0;
            arp_reply_req           <= 1'b0;
            arp_rec_source_mac_addr <= '0;
            arp_rec_source_ip_addr  <= '0;
            arp_found               <= 1'b0;
        end else begin
            arp_found <= 1'b0;
            if (arp_reply_ack)
                arp_reply_req <= 1'b0;

            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (rx_data_valid) begin
                        cnt_reg         <= CNT_W'(1);
                        bcast_match_reg <= bcast_next;
                        local_match_reg <= local_next;
                        if (rx_frame_err || mismatch)
                            state_reg <= DROP;
                        else if (!rx_frame_end)
                            state_reg <= RECV;
                    end
                end

                RECV: begin
                    if (rx_data_valid) begin
                        if (cnt_reg != '1)
                            cnt_reg <= cnt_reg + 1'b1;
                        bcast_match_reg <= bcast_next;
                        local_match_reg <= local_next;
                        if (off == 21)
                            op_reply_reg <= rx_data[1];
                        if (off >= 22 && off <= 27)
                            sha_reg <= {sha_reg[39:0], rx_data};
                        if (off >= 28 && off <= 31)
                            spa_reg <= {spa_reg[23:0], rx_data};
                        if (rx_frame_err)
                            state_reg <= DROP;
                        else if (rx_frame_end)
                            state_reg <= (!mismatch && off >= MIN_ARP_BYTES - 1) ? CHECK : IDLE;
                        else if (mismatch)
                            state_reg <= DROP;
                    end else if (rx_frame_err) begin
                        state_reg <= DROP;
                    end
                end

                DROP: begin
                    if (rx_data_valid && cnt_reg != '1)
                        cnt_reg <= cnt_reg + 1'b1;
                    // Also leave once the stream goes idle: an error that coincided
                    // with the last byte leaves no later end pulse to wait for.
                    if (rx_frame_end || !rx_data_valid)
                        state_reg <= IDLE;
                end

                CHECK: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    if (!op_reply_reg) begin
                        if (!arp_reply_req) begin
                            arp_rec_source_mac_addr <= sha_reg;
                            arp_rec_source_ip_addr  <= spa_reg;
                            arp_reply_req           <= 1'b1;
                        end
                    end else begin
                        arp_found <= 1'b1;
                        // Never overwrite the addresses the TX side still owes a reply to.
                        if (!arp_reply_req) begin
                            arp_rec_source_mac_addr <= sha_reg;
                            arp_rec_source_ip_addr  <= spa_reg;
                        end
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arp_rx.sv
// Directed bench for arp_rx: builds ARP frames, scoreboards the expected
// reply requests / found pulses and checks levels and timing at each step.
module tb_arp_rx;

    localparam logic [47:0] LMAC  = 48'h0200_00aa_bb01;
    localparam logic [31:0] LIP   = 32'hc0a8_0001;
    localparam logic [47:0] BCAST = 48'hffff_ffff_ffff;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_data_valid;
    logic        rx_frame_end;
    logic        rx_frame_err;
    logic        arp_reply_ack;
    logic        arp_reply_req;
    logic [47:0] arp_rec_source_mac_addr;
    logic [31:0] arp_rec_source_ip_addr;
    logic        arp_found;

    typedef struct packed {
        logic        is_reply;
        logic [47:0] mac;
        logic [31:0] ip;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] frm [0:63];
    int   frm_len;
    logic prev_req = 1'b0;

    always #5 clk = ~clk;

    arp_rx dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .local_mac_addr          (LMAC),
        .local_ip_addr           (LIP),
        .rx_data                 (rx_data),
        .rx_data_valid           (rx_data_valid),
        .rx_frame_end            (rx_frame_end),
        .rx_frame_err            (rx_frame_err),
        .arp_reply_ack           (arp_reply_ack),
        .arp_reply_req           (arp_reply_req),
        .arp_rec_source_mac_addr (arp_rec_source_mac_addr),
        .arp_rec_source_ip_addr  (arp_rec_source_ip_addr),
        .arp_found               (arp_found)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic build(input logic [47:0] dst, input logic [15:0] etype, input logic [7:0] op,
                         input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tpa,
                         input int len);
        for (int i = 0; i < 64; i++) frm[i] = 8'h5a;
        for (int i = 0; i < 6; i++) begin
            frm[i]      = dst[8*(5-i) +: 8];
            frm[6+i]    = sha[8*(5-i) +: 8];
            frm[22+i]   = sha[8*(5-i) +: 8];
        end
        frm[12] = etype[15:8];
        frm[13] = etype[7:0];
        frm[14] = 8'h00; frm[15] = 8'h01;
        frm[16] = 8'h08; frm[17] = 8'h00;
        frm[18] = 8'h06; frm[19] = 8'h04;
        frm[20] = 8'h00; frm[21] = op;
        for (int i = 0; i < 4; i++) begin
            frm[28+i] = spa[8*(3-i) +: 8];
            frm[38+i] = tpa[8*(3-i) +: 8];
        end
        frm_len = len;
    endtask

    // Returns at the falling edge after the last byte was sampled (DUT in CHECK).
    task automatic send(input int err_at);
        for (int i = 0; i < frm_len; i++) begin
            @(negedge clk);
            rx_data       = frm[i];
            rx_data_valid = 1'b1;
            rx_frame_end  = (i == frm_len - 1);
            rx_frame_err  = (i == err_at);
        end
        @(negedge clk);
        rx_data       = 8'h00;
        rx_data_valid = 1'b0;
        rx_frame_end  = 1'b0;
        rx_frame_err  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic is_reply, input logic [47:0] mac, input logic [31:0] ip);
        exp_t e;
        e.is_reply = is_reply;
        e.mac      = mac;
        e.ip       = ip;
        sb.push_back(e);
    endtask

    task automatic quiet(input string tag, input logic [47:0] mac, input logic [31:0] ip, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, "_req"}, 64'(arp_reply_req), 64'(0));
            chk({tag, "_found"}, 64'(arp_found), 64'(0));
        end
        chk({tag, "_mac"}, 64'(arp_rec_source_mac_addr), 64'(mac));
        chk({tag, "_ip"}, 64'(arp_rec_source_ip_addr), 64'(ip));
    endtask

    task automatic ack_req(input string tag);
        arp_reply_ack = 1'b1;
        @(negedge clk);
        arp_reply_ack = 1'b0;
        chk(tag, 64'(arp_reply_req), 64'(0));
    endtask

    // Every found pulse or rising reply request must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && (arp_found || (arp_reply_req && !prev_req))) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("sb_kind", 64'(arp_found), 64'(mon_e.is_reply));
                chk("sb_mac", 64'(arp_rec_source_mac_addr), 64'(mon_e.mac));
                chk("sb_ip", 64'(arp_rec_source_ip_addr), 64'(mon_e.ip));
            end
        end
        prev_req <= arp_reply_req;
    end

    initial begin
        logic [47:0] d;
        logic [15:0] et;
        logic [7:0]  op;
        logic [31:0] tpa;

        rst_n         = 1'b0;
        rx_data       = 8'h00;
        rx_data_valid = 1'b0;
        rx_frame_end  = 1'b0;
        rx_frame_err  = 1'b0;
        arp_reply_ack = 1'b0;
        idle(3);
        chk("rst_req", 64'(arp_reply_req), 64'(0));
        chk("rst_found", 64'(arp_found), 64'(0));
        chk("rst_mac", 64'(arp_rec_source_mac_addr), 64'(0));
        chk("rst_ip", 64'(arp_rec_source_ip_addr), 64'(0));
        rst_n = 1'b1;
        idle(2);

        // 1: broadcast request for our IP
        build(BCAST, 16'h0806, 8'h01, 48'h000a35010203, 32'hc0a80003, LIP, 60);
        push(1'b0, 48'h000a35010203, 32'hc0a80003);
        send(-1);
        chk("t1_req_in_check", 64'(arp_reply_req), 64'(0));
        @(negedge clk);
        chk("t1_req", 64'(arp_reply_req), 64'(1));
        chk("t1_mac", 64'(arp_rec_source_mac_addr), 64'h000a35010203);
        chk("t1_ip", 64'(arp_rec_source_ip_addr), 64'hc0a80003);
        idle(5);
        chk("t1_req_held", 64'(arp_reply_req), 64'(1));
        ack_req("t1_req_cleared");
        idle(2);

        // 2: unicast reply to our MAC
        build(LMAC, 16'h0806, 8'h02, 48'h001122334455, 32'hc0a80009, LIP, 42);
        push(1'b1, 48'h001122334455, 32'hc0a80009);
        send(-1);
        chk("t2_found_in_check", 64'(arp_found), 64'(0));
        @(negedge clk);
        chk("t2_found", 64'(arp_found), 64'(1));
        chk("t2_mac", 64'(arp_rec_source_mac_addr), 64'h001122334455);
        chk("t2_ip", 64'(arp_rec_source_ip_addr), 64'hc0a80009);
        chk("t2_req", 64'(arp_reply_req), 64'(0));
        @(negedge clk);
        chk("t2_found_pulse", 64'(arp_found), 64'(0));
        idle(2);

        // 3: one mismatching field per frame
        for (int v = 0; v < 4; v++) begin
            d   = (v == 2) ? 48'h0200_00aa_bb02 : BCAST;
            et  = (v == 0) ? 16'h0800 : 16'h0806;
            tpa = (v == 1) ? LIP + 32'd1 : LIP;
            op  = (v == 3) ? 8'h03 : 8'h01;
            build(d, et, op, 48'h00bad0bad001, 32'hc0a800ee, tpa, 60);
            send(-1);
            quiet($sformatf("t3_v%0d", v), 48'h001122334455, 32'hc0a80009, 3);
        end

        // 4: truncated frame, then error mid-frame, then a good request
        build(BCAST, 16'h0806, 8'h01, 48'h0a0b0c0d0e0f, 32'hc0a80004, LIP, 41);
        send(-1);
        quiet("t4_short", 48'h001122334455, 32'hc0a80009, 3);
        build(BCAST, 16'h0806, 8'h01, 48'h0a0b0c0d0e0f, 32'hc0a80004, LIP, 60);
        send(30);
        quiet("t4_err", 48'h001122334455, 32'hc0a80009, 3);
        build(BCAST, 16'h0806, 8'h01, 48'h0a0b0c0d0e0f, 32'hc0a80004, LIP, 42);
        push(1'b0, 48'h0a0b0c0d0e0f, 32'hc0a80004);
        send(-1);
        @(negedge clk);
        chk("t4_req", 64'(arp_reply_req), 64'(1));
        chk("t4_mac", 64'(arp_rec_source_mac_addr), 64'h0a0b0c0d0e0f);
        ack_req("t4_req_cleared");
        idle(2);

        // 5: second request while one is pending
        build(LMAC, 16'h0806, 8'h01, 48'h00aabbccddee, 32'hc0a80005, LIP, 60);
        push(1'b0, 48'h00aabbccddee, 32'hc0a80005);
        send(-1);
        @(negedge clk);
        chk("t5_req_a", 64'(arp_reply_req), 64'(1));
        idle(2);
        build(BCAST, 16'h0806, 8'h01, 48'h001111111111, 32'hc0a80006, LIP, 60);
        send(-1);
        idle(3);
        chk("t5_req_still", 64'(arp_reply_req), 64'(1));
        chk("t5_mac_kept", 64'(arp_rec_source_mac_addr), 64'h00aabbccddee);
        chk("t5_ip_kept", 64'(arp_rec_source_ip_addr), 64'hc0a80005);
        ack_req("t5_req_cleared");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_no_reassert", 64'(arp_reply_req), 64'(0));
        end

        // 6: reset in the middle of a frame
        build(BCAST, 16'h0806, 8'h01, 48'h00deadbeef01, 32'hc0a80007, LIP, 60);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            rx_data       = frm[i];
            rx_data_valid = 1'b1;
        end
        @(negedge clk);
        rst_n         = 1'b0;
        rx_data_valid = 1'b0;
        rx_data       = 8'h00;
        #1;
        chk("t6_rst_req", 64'(arp_reply_req), 64'(0));
        chk("t6_rst_found", 64'(arp_found), 64'(0));
        chk("t6_rst_mac", 64'(arp_rec_source_mac_addr), 64'(0));
        chk("t6_rst_ip", 64'(arp_rec_source_ip_addr), 64'(0));
        idle(2);
        rst_n = 1'b1;
        idle(2);
        build(BCAST, 16'h0806, 8'h01, 48'h00cafe000001, 32'hc0a80008, LIP, 60);
        push(1'b0, 48'h00cafe000001, 32'hc0a80008);
        send(-1);
        @(negedge clk);
        chk("t6_req", 64'(arp_reply_req), 64'(1));
        chk("t6_mac", 64'(arp_rec_source_mac_addr), 64'h00cafe000001);
        chk("t6_ip", 64'(arp_rec_source_ip_addr), 64'hc0a80008);
        ack_req("t6_req_cleared");

        idle(3);
        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
